// File: rtl/window_gen3x3.sv
// 3x3 sliding-window generator that feeds the convolution core one packed {kernel, window} word per handshake.
// Optional WIN_COUNT_EN adds win_count, the number of windows transferred in the current frame.
module window_gen3x3 #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   pix_in,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic [35:0]  kernel_in,
  input  logic         kernel_load,
  input  logic         target_ready,
  output logic         valid,
  output logic [107:0] dataOut,
  output logic         frame_done
`ifdef WIN_COUNT_EN
  ,
  output logic [15:0]  win_count
`endif
);

  typedef enum logic [1:0] {FILL, EMIT, HOLD} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [7:0]            lb0 [IMG_WIDTH];
  logic [7:0]            lb1 [IMG_WIDTH];
  logic [2:0][2:0][7:0]  win, win_nxt;   // [row: 0=top][col: 0=left]
  logic [71:0]           pix_word;
  logic [35:0]           kern;
  logic                  accept, last_col, last_row, win_done;

  assign pix_ready = (state == FILL);
  assign valid     = (state == EMIT);
  assign accept    = pix_valid && pix_ready;
  assign last_col  = (col == CW'(IMG_WIDTH - 1));
  assign last_row  = (row == RW'(IMG_HEIGHT - 1));
  // Columns 0/1 of a row still hold the previous row's tail, so only col>=2 is a real window.
  assign win_done  = accept && (row >= RW'(2)) && (col >= CW'(2));

  always_comb begin
    win_nxt = win;
    for (int r = 0; r < 3; r++) begin
      win_nxt[r][0] = win[r][1];
      win_nxt[r][1] = win[r][2];
    end
    win_nxt[0][2] = lb0[col];
    win_nxt[1][2] = lb1[col];
    win_nxt[2][2] = pix_in;
  end

  always_comb begin
    pix_word = '0;
    for (int i = 0; i < 9; i++)
      pix_word[71-8*i -: 8] = win_nxt[i/3][i%3];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (win_done) state_nxt = EMIT;
      EMIT:    if (target_ready) state_nxt = HOLD;
      HOLD:    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FILL;
      col        <= '0;
      row        <= '0;
      dataOut    <= '0;
      frame_done <= 1'b0;
      kern       <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= accept && last_col && last_row;
      if (kernel_load) kern <= kernel_in;
      // Word captures the kernel held before this edge; a same-edge load lands in the next word.
      if (win_done) dataOut <= {kern, pix_word};
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Pixel storage carries no reset; its contents are irrelevant until refilled.
  always_ff @(posedge clk) begin
    if (rst && accept) begin
      win      <= win_nxt;
      lb0[col] <= lb1[col];
      lb1[col] <= pix_in;
    end
  end

`ifdef WIN_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst)
      win_count <= '0;
    else if (accept && last_col && last_row)
      win_count <= '0;
    else if (state == EMIT && target_ready && win_count != 16'hFFFF)
      win_count <= win_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_window_gen3x3.sv
// Bench for window_gen3x3 (4x4 image): image-level reference model compared every cycle, directed scenarios plus random traffic.
module tb_window_gen3x3;
  localparam int W = 4;
  localparam int H = 4;
  localparam logic [35:0] K1 = 36'h111111111;
  localparam logic [35:0] K2 = 36'h123456789;
  localparam logic [71:0] P1 = 72'h010203_050607_090A0B;
  localparam logic [71:0] P2 = 72'h020304_060708_0A0B0C;
  localparam logic [71:0] P3 = 72'h050607_090A0B_0D0E0F;
  localparam logic [71:0] P4 = 72'h060708_0A0B0C_0E0F10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   pix_in = 8'h55;
  logic         pix_valid = 1'b1;
  logic         pix_ready;
  logic [35:0]  kernel_in = '0;
  logic         kernel_load = 1'b0;
  logic         target_ready = 1'b0;
  logic         valid;
  logic [107:0] dataOut;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  window_gen3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .kernel_in(kernel_in), .kernel_load(kernel_load), .target_ready(target_ready),
    .valid(valid), .dataOut(dataOut), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [107:0] act, input logic [107:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the frame as a 2D image, windows cut straight out of it.
  logic [7:0]   img [H][W];
  logic [107:0] mlog [$];
  logic         started = 1'b0;
  logic         m_ready, m_valid, m_hold, m_fd;
  logic [107:0] m_data;
  logic [35:0]  m_kern;
  int           m_cnt;
  int           fd_cnt = 0;

  function automatic logic [107:0] mk_word(input int r, input int c, input logic [35:0] k);
    logic [71:0] p;
    p = '0;
    for (int i = 0; i < 9; i++) p[71-8*i -: 8] = img[r-2+i/3][c-2+i%3];
    return {k, p};
  endfunction

  always @(negedge clk) begin
    int r, c;
    if (started) begin
      chk("valid", 108'(valid), 108'(m_valid));
      chk("pix_ready", 108'(pix_ready), 108'(m_ready));
      chk("frame_done", 108'(frame_done), 108'(m_fd));
      chk("dataOut", dataOut, m_data);
      if (frame_done) fd_cnt++;
    end
    if (!rst) begin
      started = 1'b1;
      m_cnt = 0; m_ready = 1'b1; m_valid = 1'b0; m_hold = 1'b0;
      m_fd = 1'b0; m_data = '0; m_kern = '0;
    end else if (started) begin
      m_fd = 1'b0;
      if (m_ready && pix_valid) begin
        r = m_cnt / W;
        c = m_cnt % W;
        img[r][c] = pix_in;
        m_fd = (m_cnt == W*H - 1);
        if (r >= 2 && c >= 2) begin
          m_data  = mk_word(r, c, m_kern);
          m_ready = 1'b0;
          m_valid = 1'b1;
        end
        m_cnt = (m_cnt + 1) % (W*H);
      end else if (m_valid && target_ready) begin
        mlog.push_back(m_data);
        m_valid = 1'b0;
        m_hold  = 1'b1;
      end else if (m_hold) begin
        m_hold  = 1'b0;
        m_ready = 1'b1;
      end
      if (kernel_load) m_kern = kernel_in;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that took the pixel.
  task automatic send_pix(input logic [7:0] p);
    int  n;
    logic done;
    pix_in = p; pix_valid = 1'b1; done = 1'b0; n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (pix_ready) done = 1'b1;
    end
    if (!done) chk("send_timeout", 108'(pix_ready), 108'(1));
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int  base, fd0;
    logic acc;
    // Reset held with a pixel offered: nothing may be consumed
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 108'(valid), 108'(0));
    chk("rst_pix_ready", 108'(pix_ready), 108'(1));
    chk("rst_dataOut", dataOut, 108'(0));
    chk("rst_frame_done", 108'(frame_done), 108'(0));
    @(posedge clk); #1;
    rst = 1'b1; pix_valid = 1'b0;
    kernel_load = 1'b1; kernel_in = K1;
    @(posedge clk); #1;
    kernel_load = 1'b0;

    // Full 4x4 frame, core always ready
    target_ready = 1'b1;
    base = mlog.size();
    for (int p = 1; p <= 16; p++) begin
      send_pix(8'(p));
      if (p == 11) begin
        @(negedge clk);
        chk("first_valid", 108'(valid), 108'(1));
        @(posedge clk); #1;
      end
    end
    idle(5);
    chk("f1_words", 108'(mlog.size() - base), 108'(4));
    chk("f1_w0", mlog[base+0], {K1, P1});
    chk("f1_w1", mlog[base+1], {K1, P2});
    chk("f1_w2", mlog[base+2], {K1, P3});
    chk("f1_w3", mlog[base+3], {K1, P4});

    // Backpressure on window 1 with a kernel swap during its EMIT
    base = mlog.size();
    target_ready = 1'b0;
    for (int p = 1; p <= 11; p++) send_pix(8'(p));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      kernel_load = (i == 1);
      kernel_in   = K2;
      @(negedge clk);
      chk("bp_valid", 108'(valid), 108'(1));
      chk("bp_pix_ready", 108'(pix_ready), 108'(0));
      chk("bp_dataOut", dataOut, {K1, P1});
    end
    @(posedge clk); #1;
    kernel_load = 1'b0; target_ready = 1'b1;
    for (int p = 12; p <= 16; p++) send_pix(8'(p));
    idle(5);
    chk("swap_words", 108'(mlog.size() - base), 108'(4));
    chk("swap_w0", mlog[base+0], {K1, P1});
    chk("swap_w1", mlog[base+1], {K2, P2});

    // Two frames back to back
    base = mlog.size();
    fd0  = fd_cnt;
    for (int i = 0; i < 32; i++) send_pix(8'((i % 16) + 1));
    idle(5);
    chk("b2b_words", 108'(mlog.size() - base), 108'(8));
    chk("b2b_frame_done", 108'(fd_cnt - fd0), 108'(2));
    chk("b2b_f1_first", mlog[base+0], {K2, P1});
    chk("b2b_f2_first", mlog[base+4], {K2, P1});
    chk("b2b_f2_last", mlog[base+7], {K2, P4});

    // Reset while a word waits in EMIT; kernel returns to zero
    target_ready = 1'b0;
    for (int p = 1; p <= 11; p++) send_pix(8'(p));
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 108'(valid), 108'(0));
    chk("mid_rst_pix_ready", 108'(pix_ready), 108'(1));
    @(posedge clk); #1;
    base = mlog.size();
    target_ready = 1'b1;
    for (int p = 1; p <= 16; p++) send_pix(8'(p));
    idle(5);
    chk("mid_rst_words", 108'(mlog.size() - base), 108'(4));
    chk("mid_rst_w0", mlog[base+0], {36'h0, P1});
    chk("mid_rst_w3", mlog[base+3], {36'h0, P4});

    // Random traffic, model-checked every cycle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc = pix_valid && pix_ready && rst;
      @(posedge clk); #1;
      if (acc) pix_valid = 1'b0;
      rst = ($urandom % 500 != 0);
      if (!pix_valid && ($urandom % 4 != 0)) begin
        pix_valid = 1'b1;
        pix_in    = 8'($urandom);
      end
      kernel_load  = !pix_valid && ($urandom % 6 == 0);
      kernel_in    = 36'({$urandom, $urandom});
      target_ready = ($urandom % 3 != 0);
    end
    @(posedge clk); #1;
    rst = 1'b1; pix_valid = 1'b0; kernel_load = 1'b0; target_ready = 1'b1;
    idle(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_gen3x3.md
Name: window_gen3x3

Overview:
- Upstream feeder for the 3x3 convolution core.
- Accepts a raster-order 8-bit pixel stream and buffers the two previous image rows in line buffers.
- Forms every fully-interior 3x3 window.
- Packs each window with a 9x4-bit kernel into the core's 108-bit input word, using the core's valid/ready handshake.

Parameters:
- IMG_WIDTH, 8, pixels per row (min 3).
- IMG_HEIGHT, 8, rows per frame (min 3).
- CW, $clog2(IMG_WIDTH), column counter width.
- RW, $clog2(IMG_HEIGHT), row counter width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- pix_in  in  8  raster-order pixel.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  block can accept pix_in.
- kernel_in  in  36  k0 in [35:32] ... k8 in [3:0].
- kernel_load  in  1  capture kernel_in this cycle.
- target_ready  in  1  from core's ready.
- valid  out  1  to core's source_valid.
- dataOut  out  108  packed word to core's dataIn.
- frame_done  out  1  one-cycle pulse on the last pixel of a frame.

Behaviour:
- Reset (rst==0 at a rising edge):
  - State FILL; col=0, row=0; valid=0; pix_ready=1; dataOut=0; frame_done=0; kernel reg=0.
  - Line-buffer and window contents are don't-care.
- Pixel accept: edge where pix_valid && pix_ready.
  - Window shifts left one column; new right column = {lb0[col], lb1[col], pix_in} (top, mid, bottom).
  - Then lb0[col] <= lb1[col] and lb1[col] <= pix_in.
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments; at IMG_HEIGHT-1 row wraps to 0.
- Window emission:
  - An accepted pixel with row>=2 and col>=2 completes a window.
  - Result: (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame, no padding.
  - Windows for col<2 (stale previous-row columns) are never emitted.
- Packing of dataOut:
  - [107:72] = kernel reg (k0 at [107:104]).
  - [71:64] = top-left p0, row-major through p8 (bottom-right) at [7:0].
- FSM:
  - FILL: pix_ready=1, valid=0. A window-completing accept registers dataOut and goes to EMIT. Any other accept stays in FILL.
  - EMIT: valid=1, pix_ready=0, dataOut stable. Edge with target_ready=1 completes the transfer and goes to HOLD. Otherwise stays in EMIT indefinitely with dataOut stable.
  - HOLD: exactly one cycle; valid=0, pix_ready=0, dataOut unchanged. This covers the core sampling dataIn one cycle after the handshake. Then goes to FILL.
- Latency: window-completing pixel accepted at edge N → valid=1 in cycle N+1. Minimum 3 cycles per emitted window; 1 cycle per non-emitting pixel.
- Kernel load:
  - kernel_load=1 captures kernel_in on any edge, in any state.
  - The new kernel appears in the next word registered on entry to EMIT.
  - A word already in EMIT/HOLD keeps its old kernel.
- frame_done:
  - Pulses in cycle N+1 when the pixel with row=IMG_HEIGHT-1, col=IMG_WIDTH-1 is accepted at edge N.
  - That pixel's window is still emitted normally.
  - The next frame starts at row 0 / col 0 with no idle gap required.
- Edge cases:
  - pix_valid while pix_ready=0: ignored; the source holds the pixel.
  - target_ready high outside EMIT: ignored.
  - Reset mid-frame or mid-EMIT: immediate return to reset values; the pending word is dropped and the partial frame discarded.

Optional Feature:
- Macro: WIN_COUNT_EN.
- Defined:
  - Adds output win_count[15:0]: windows transferred in the current frame.
  - Increments on each EMIT→HOLD transition.
  - Cleared by reset and on the cycle frame_done pulses; the frame's final window is then counted from 1 in the next frame only if it was transferred after the pulse.
  - Saturates at 16'hFFFF.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with pix_valid=1 → valid=0, pix_ready=1, dataOut=0, frame_done=0; no pixel consumed.
- 4x4 frame (params 4/4): kernel_load with 36'h111111111, pixels 1..16, target_ready=1 (model the core: ready drops in HOLD) → 4 words:
  - {36'h111111111, 72'h01_02_03_05_06_07_09_0A_0B}
  - then ...02_03_04_06_07_08_0A_0B_0C
  - then ...05_06_07_09_0A_0B_0D_0E_0F
  - then ...06_07_08_0A_0B_0C_0E_0F_10
  - valid first rises the cycle after pixel 11 is accepted.
- Backpressure: target_ready=0 for 5 cycles during EMIT → valid=1, dataOut constant, pix_ready=0. Raise target_ready → one HOLD cycle with dataOut unchanged, then pix_ready=1.
- Kernel swap: kernel_load 36'h123456789 during EMIT of window 1 → window 1 carries 36'h111111111; window 2 carries 36'h123456789.
- Back-to-back frames: 32 pixels streamed continuously → 8 words; frame_done pulses after pixels 16 and 32; second frame's first word equals the first frame's if pixel data repeats.
- Mid-frame reset: rst=0 during EMIT after pixel 11 → valid=0 next cycle. Restart with pixels 1..16 → exactly 4 correct words.
